alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the next-generation BIP datapath; replaces the two-operation combinational add/sub ALU.
- Adds logic ops, iterative shifts, registered Z/N/C/V flags and a start/done handshake so the control FSM can stall on long operations.
- Sits between the accumulator/operand registers and the status register.
- Result and flags are registered and held until the next completion.

Parameters:
- DATA_WIDTH, 16, operand/result width in bits; must be >= 4.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), width of the shift-amount field taken from alu_B_in.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- alu_start_in  input  1  request; sampled only when idle.
- alu_op_in  input  4  operation code (see alu_pkg).
- alu_A_in  input  DATA_WIDTH  operand A; captured on accept.
- alu_B_in  input  DATA_WIDTH  operand B; captured on accept.
- alu_out  output  DATA_WIDTH  registered result.
- alu_Z_out, alu_N_out, alu_C_out, alu_V_out  output  1 each  registered flags.
- alu_busy_out  output  1  high while a multi-cycle op runs.
- alu_done_out  output  1  one-cycle pulse; result and flags valid from this cycle.

Behaviour:
- Reset (async assert, sync release): state IDLE; alu_out=0; Z=N=C=V=0; busy=0; done=0. Reset mid-operation abandons the operation and produces no done pulse.
- Ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SLL, 7 SRL, 8 SRA, 9 MUL (only with the macro). Every other code completes in 1 cycle with result 0, Z=1, N=C=V=0.
- Accept: alu_start_in=1 in IDLE at edge k. A, B and op are captured on that edge. alu_start_in is ignored while busy.
- Single-cycle ops (ADD..NOT, shifts with amount 0, undefined codes): result, flags and done are updated at edge k. done is visible in the cycle after start.
- Shifts: s = alu_B_in[SHAMT_WIDTH-1:0].
  - s>0: state SHIFT, counter=s; one 1-bit shift per edge k+1..k+s.
  - done_out and result appear after edge k+s; busy is high from edge k until edge k+s.
  - SRA replicates the MSB; SLL and SRL fill with 0.
- States: IDLE, SHIFT, MUL. SHIFT/MUL -> IDLE on the completing edge, with done=1 in that same edge.
- Back-to-back: a start in the cycle where done=1 is accepted, since the state is IDLE.
- Flags (all updated only when done rises):
  - Z = (result==0); N = result[MSB].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (A<B unsigned); V = signed overflow.
  - Logic ops: C=V=0.
  - Shifts: C = last bit shifted out (0 if s=0); V=0.
- alu_out and the flags hold their values between done pulses. done is never asserted for two consecutive cycles from a single op.
- Arithmetic wraps modulo 2^DATA_WIDTH.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: op 9 runs an unsigned shift-add multiply using state MUL for DATA_WIDTH iterations.
  - done appears after edge k+DATA_WIDTH.
  - Result = low DATA_WIDTH bits of A*B.
  - C = 1 if the high half is nonzero; V=0.
- Undefined: no MUL state or multiplier hardware is built; op 9 is an undefined code (1 cycle, result 0, Z=1).

Decomposition:
- Package alu_pkg holds:
  - alu_op_e: 4-bit op enum.
  - alu_state_e: IDLE/SHIFT/MUL.
  - Localparams for the op codes.
- Sub-module alu_flag_gen: combinational Z/N/C/V from result, operands, op and carry/shift-out bit. It is reused by the status register logic.

Test Plan:
- Reset with rst_n_in=0 mid-SHIFT (s=5, 2 shifts done) -> outputs 0 immediately, no done pulse. After release, IDLE, busy=0.
- ADD A=16'h7FFF B=16'h0001 -> done 1 cycle after start; out=16'h8000, N=1, V=1, C=0, Z=0.
- SUB A=16'h0003 B=16'h0005 -> out=16'hFFFE, C=1, N=1, V=0. SUB A=B=16'h1234 -> out=0, Z=1.
- SRA A=16'h8001 B=3 -> busy for 3 cycles; done after edge k+3; out=16'hF000, C=0. SLL A=16'h8001 B=1 -> out=16'h0002, C=1.
- Back-to-back: a start held high during a shift is ignored. A new start (AND A=16'hF0F0 B=16'h0FF0) in the done cycle -> out=16'h00F0 done in the next cycle. Op 12 -> out=0, Z=1.
- ALU_MUL_EN: MUL A=16'h0100 B=16'h0100 -> done after 16 cycles; out=0, C=1, Z=1. Without the macro, op 9 -> 1 cycle, out=0, Z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state encodings.
package alu_pkg;

  localparam logic [3:0] OpCodeAdd = 4'd0;
  localparam logic [3:0] OpCodeSub = 4'd1;
  localparam logic [3:0] OpCodeAnd = 4'd2;
  localparam logic [3:0] OpCodeOr  = 4'd3;
  localparam logic [3:0] OpCodeXor = 4'd4;
  localparam logic [3:0] OpCodeNot = 4'd5;
  localparam logic [3:0] OpCodeSll = 4'd6;
  localparam logic [3:0] OpCodeSrl = 4'd7;
  localparam logic [3:0] OpCodeSra = 4'd8;
  localparam logic [3:0] OpCodeMul = 4'd9;

  typedef enum logic [3:0] {
    OpAdd = OpCodeAdd,
    OpSub = OpCodeSub,
    OpAnd = OpCodeAnd,
    OpOr  = OpCodeOr,
    OpXor = OpCodeXor,
    OpNot = OpCodeNot,
    OpSll = OpCodeSll,
    OpSrl = OpCodeSrl,
    OpSra = OpCodeSra,
    OpMul = OpCodeMul
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StMul
  } alu_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C/V generation; cbit carries the adder carry-out, the last
// shifted-out bit, or the multiply high-half-nonzero indication.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] result,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_e               op,
  input  logic                  cbit,
  output logic                  z,
  output logic                  n,
  output logic                  c,
  output logic                  v
);

  localparam int unsigned Msb = DATA_WIDTH - 1;

  always_comb begin
    z = (result == '0);
    n = result[Msb];
    c = 1'b0;
    v = 1'b0;
    case (op)
      OpAdd: begin
        c = cbit;
        v = (a[Msb] == b[Msb]) && (result[Msb] != a[Msb]);
      end
      OpSub: begin
        c = (a < b);
        v = (a[Msb] != b[Msb]) && (result[Msb] != a[Msb]);
      end
      OpSll, OpSrl, OpSra, OpMul: c = cbit;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with start/done handshake, iterative shifts and registered flags.
// Define ALU_MUL_EN to build the shift-add multiplier (op 9).
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  alu_start_in,
  input  logic [3:0]            alu_op_in,
  input  logic [DATA_WIDTH-1:0] alu_A_in,
  input  logic [DATA_WIDTH-1:0] alu_B_in,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  alu_Z_out,
  output logic                  alu_N_out,
  output logic                  alu_C_out,
  output logic                  alu_V_out,
  output logic                  alu_busy_out,
  output logic                  alu_done_out
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  alu_state_e      state_q, state_d;
  alu_op_e         op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [W-1:0]    res_q, res_d;
  logic            z_q, n_q, c_q, v_q;
  logic            done_q;

  alu_op_e          op_in;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [W:0]       add_full;
  logic [W-1:0]     step_val;
  logic             step_bit;

  logic             fin;
  logic [W-1:0]     fin_res;
  alu_op_e          fin_op;
  logic             fin_cbit;
  logic             fz, fn, fc, fv;

`ifdef ALU_MUL_EN
  logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [W-1:0]   mplier_q, mplier_d;
`endif

  assign op_in    = alu_op_e'(alu_op_in);
  assign shamt    = alu_B_in[SHAMT_WIDTH-1:0];
  assign add_full = {1'b0, alu_A_in} + {1'b0, alu_B_in};

  // One 1-bit shift of the working register per cycle in StShift.
  always_comb begin
    step_val = sh_q;
    step_bit = 1'b0;
    case (op_q)
      OpSll: begin step_val = {sh_q[W-2:0], 1'b0};     step_bit = sh_q[W-1]; end
      OpSrl: begin step_val = {1'b0, sh_q[W-1:1]};     step_bit = sh_q[0];   end
      OpSra: begin step_val = {sh_q[W-1], sh_q[W-1:1]}; step_bit = sh_q[0];  end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    fin      = 1'b0;
    fin_res  = '0;
    fin_op   = op_in;
    fin_cbit = 1'b0;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
    case (state_q)
      StIdle: begin
        if (alu_start_in) begin
          op_d = op_in;
          case (op_in)
            OpAdd: begin fin = 1'b1; fin_res = add_full[W-1:0]; fin_cbit = add_full[W]; end
            OpSub: begin fin = 1'b1; fin_res = alu_A_in - alu_B_in; end
            OpAnd: begin fin = 1'b1; fin_res = alu_A_in & alu_B_in; end
            OpOr:  begin fin = 1'b1; fin_res = alu_A_in | alu_B_in; end
            OpXor: begin fin = 1'b1; fin_res = alu_A_in ^ alu_B_in; end
            OpNot: begin fin = 1'b1; fin_res = ~alu_A_in; end
            OpSll, OpSrl, OpSra: begin
              if (shamt == '0) begin
                fin     = 1'b1;
                fin_res = alu_A_in;
              end else begin
                state_d = StShift;
                cnt_d   = CntW'(shamt);
                sh_d    = alu_A_in;
              end
            end
`ifdef ALU_MUL_EN
            OpMul: begin
              state_d  = StMul;
              cnt_d    = CntW'(W);
              acc_d    = '0;
              mcand_d  = {{W{1'b0}}, alu_A_in};
              mplier_d = alu_B_in;
            end
`endif
            default: begin fin = 1'b1; fin_res = '0; end
          endcase
        end
      end
      StShift: begin
        sh_d  = step_val;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          fin      = 1'b1;
          fin_res  = step_val;
          fin_cbit = step_bit;
          fin_op   = op_q;
          state_d  = StIdle;
        end
      end
      StMul: begin
`ifdef ALU_MUL_EN
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          fin      = 1'b1;
          fin_res  = acc_step[W-1:0];
          fin_cbit = |acc_step[2*W-1:W];
          fin_op   = OpMul;
          state_d  = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
    res_d = fin ? fin_res : res_q;
  end

  alu_flag_gen #(
    .DATA_WIDTH(W)
  ) u_flag_gen (
    .result(fin_res),
    .a     (alu_A_in),
    .b     (alu_B_in),
    .op    (fin_op),
    .cbit  (fin_cbit),
    .z     (fz),
    .n     (fn),
    .c     (fc),
    .v     (fv)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      cnt_q    <= '0;
      sh_q     <= '0;
      res_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      res_q    <= res_d;
      done_q   <= fin;
      if (fin) begin
        z_q <= fz;
        n_q <= fn;
        c_q <= fc;
        v_q <= fv;
      end
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign alu_out      = res_q;
  assign alu_Z_out    = z_q;
  assign alu_N_out    = n_q;
  assign alu_C_out    = c_q;
  assign alu_V_out    = v_q;
  assign alu_busy_out = (state_q != StIdle);
  assign alu_done_out = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc; flags are compared packed as {Z,N,C,V}.
module tb_alu_mc;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] out;
  logic         z, n, c, v, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  alu_mc #(
    .DATA_WIDTH(W)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .alu_start_in(start),
    .alu_op_in   (op),
    .alu_A_in    (a),
    .alu_B_in    (b),
    .alu_out     (out),
    .alu_Z_out   (z),
    .alu_N_out   (n),
    .alu_C_out   (c),
    .alu_V_out   (v),
    .alu_busy_out(busy),
    .alu_done_out(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done; lat counts edges after the accept edge.
  task automatic run(input string tag, input logic [3:0] o, input logic [W-1:0] aa,
                     input logic [W-1:0] bb, input int exp_lat, input logic [W-1:0] exp_out,
                     input logic [3:0] exp_f);
    int   lat;
    logic busy_seen;
    @(negedge clk);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_seen = busy;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " out"}, out, exp_out);
    check({tag, " flags"}, {z, n, c, v}, exp_f);
    check({tag, " busy"}, busy_seen, exp_lat > 0);
    @(posedge clk); #1;
    check({tag, " pulse"}, done, 1'b0);
    check({tag, " hold"}, out, exp_out);
  endtask

  initial begin
    int lat;
    logic done_seen;

    #2 rst_n = 1'b0;
    #1;
    check("rst out", out, 16'h0);
    check("rst flags", {z, n, c, v}, 4'b0000);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run("add ovf",  4'd0, 16'h7FFF, 16'h0001, 0, 16'h8000, 4'b0101);
    run("add carry", 4'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 4'b1010);
    run("sub borrow", 4'd1, 16'h0003, 16'h0005, 0, 16'hFFFE, 4'b0110);
    run("sub zero", 4'd1, 16'h1234, 16'h1234, 0, 16'h0000, 4'b1000);
    run("sub ovf",  4'd1, 16'h8000, 16'h0001, 0, 16'h7FFF, 4'b0001);
    run("or",       4'd3, 16'h1200, 16'h0034, 0, 16'h1234, 4'b0000);
    run("xor",      4'd4, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 4'b1000);
    run("not",      4'd5, 16'h0000, 16'h5555, 0, 16'hFFFF, 4'b0100);
    run("sra3",     4'd8, 16'h8001, 16'h0003, 3, 16'hF000, 4'b0100);
    run("sll1",     4'd6, 16'h8001, 16'h0001, 1, 16'h0002, 4'b0010);
    run("srl0",     4'd7, 16'hABCD, 16'h0000, 0, 16'hABCD, 4'b0100);
    run("srl4 hib", 4'd7, 16'hABCD, 16'h0014, 4, 16'h0ABC, 4'b0010);
    run("op12",     4'd12, 16'h1111, 16'h2222, 0, 16'h0000, 4'b1000);
`ifdef ALU_MUL_EN
    run("mul",      4'd9, 16'h0100, 16'h0100, 16, 16'h0000, 4'b1010);
    run("mul small", 4'd9, 16'h0012, 16'h0034, 16, 16'h03A8, 4'b0000);
`else
    run("op9 undef", 4'd9, 16'h0100, 16'h0100, 0, 16'h0000, 4'b1000);
`endif

    // Load a nonzero result, then reset in the middle of a 5-step shift.
    run("pre rst",  4'd5, 16'h0F0F, 16'h0000, 0, 16'hF0F0, 4'b0100);
    @(negedge clk);
    start = 1'b1; op = 4'd6; a = 16'h0001; b = 16'h0005;
    @(posedge clk); #1;
    start = 1'b0;
    check("mid busy", busy, 1'b1);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid rst out", out, 16'h0);
    check("mid rst flags", {z, n, c, v}, 4'b0000);
    check("mid rst busy", busy, 1'b0);
    check("mid rst done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      done_seen = done_seen | done;
    end
    check("post rst nodone", done_seen, 1'b0);
    check("post rst busy", busy, 1'b0);
    check("post rst out", out, 16'h0);

    // Start held through a shift is ignored; the op presented in the done cycle is taken.
    @(negedge clk);
    start = 1'b1; op = 4'd8; a = 16'h8001; b = 16'h0003;
    @(posedge clk); #1;
    op = 4'd2; a = 16'hF0F0; b = 16'h0FF0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b sra lat", lat, 3);
    check("b2b sra out", out, 16'hF000);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b and done", done, 1'b1);
    check("b2b and out", out, 16'h00F0);
    check("b2b and flags", {z, n, c, v}, 4'b0000);
    @(posedge clk); #1;
    check("b2b pulse end", done, 1'b0);
    check("b2b busy", busy, 1'b0);
    check("b2b hold", out, 16'h00F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
